instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have port CLKb, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Clear, input, 1, reset, asynchronous, active-high.
REQ-004 The block SHALL have port Run, input, 1, start-instruction request, sampled only in T0.
REQ-005 The block SHALL have port Instr, input, 10, instruction register output: [9:6] opcode, [5:3] Rx, [2:0] Ry.
REQ-006 The block SHALL have port IR_EN, output, 1, instruction register load enable.
REQ-007 The block SHALL have port Rin, output, 8, one-hot register write enables.
REQ-008 The block SHALL have port Rout, output, 8, one-hot register bus-drive enables.
REQ-009 The block SHALL have ports Ain, Gin, Gout, ExtOut, each output, 1: A load, G load, G bus drive, and immediate (zero-extended Ry) bus drive.
REQ-010 The block SHALL have port ALUcont, output, 4, ALU operation select.
REQ-011 The block SHALL have ports Done (output, 1, final step of instruction) and Tstep (output, 2, current timestep).
REQ-012 The block SHALL have port Illegal, output, 1, illegal-opcode trap flag.

Function
REQ-013 The timestep FSM SHALL have states T0 (00), T1 (01), T2 (10), T3 (11), reported on Tstep.
REQ-014 In T0, IR_EN SHALL equal Run, and all other control outputs SHALL be 0.
REQ-015 T0 SHALL go to T1 when Run=1; otherwise it stays in T0.
REQ-016 Run SHALL be ignored in T1-T3; no restart or abort occurs mid-instruction.
REQ-017 Outputs SHALL be combinational from state and Instr; the IR captures on the falling edge, so Instr is stable by T1.
REQ-018 Opcode 0000 (MOV): T1 SHALL assert Rout[Ry], Rin[Rx] and Done.
REQ-019 Opcode 0001 (LDI): T1 SHALL assert ExtOut, Rin[Rx] and Done.
REQ-020 For opcodes 0010 ADD, 0011 SUB, 0100 AND, 0101 OR, 0110 XOR: T1 SHALL assert Rout[Rx] and Ain; T2 SHALL assert Rout[Ry] and Gin with ALUcont; T3 SHALL assert Gout, Rin[Rx] and Done.
REQ-021 For opcode 0111 (NOT): T1 SHALL assert Rout[Rx] and Ain; T2 SHALL assert Gin with ALUcont and no bus driver; T3 SHALL assert Gout, Rin[Rx] and Done.
REQ-022 ALUcont encoding SHALL be ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, NOT 0101, and 0000 whenever Gin=0.
REQ-023 The step asserting Done SHALL be followed by T0 on the next edge.
REQ-024 At most one of Rout, Gout and ExtOut SHALL be active in any cycle.
REQ-025 Rx=Ry SHALL be legal: MOV R3,R3 asserts Rout[3] and Rin[3] together.
REQ-026 Opcodes 1000-1111 SHALL be illegal; handling is per REQ-030/031.

Reset
REQ-027 Clear=1 SHALL immediately force T0 and clear Illegal, independent of CLKb.
REQ-028 While Clear=1, all outputs SHALL be 0, including IR_EN.
REQ-029 Clear asserted mid-instruction SHALL abandon the instruction with no further Rin pulse, and Done SHALL NOT be asserted.

Configuration
REQ-030 With macro ILLEGAL_TRAP_EN defined: an illegal opcode in T1 SHALL set Illegal (sticky until Clear), assert no Rin/Done, and hold the FSM in T1 ignoring Run until Clear.
REQ-031 Without ILLEGAL_TRAP_EN: an illegal opcode SHALL execute as NOP (T1 asserts only Done, then T0), and Illegal SHALL be tied to 0.

Verification
REQ-032 Clear pulse, then Run=1 with Instr=0000_010_101 -> IR_EN=1 in T0; T1: Rout=0010_0000, Rin=0000_0100, Done=1; next Tstep=00.
REQ-033 Instr=0010_001_110 (ADD R1,R6) -> T1 Rout[1], Ain; T2 Rout[6], Gin, ALUcont=0000; T3 Gout, Rin[1], Done; four cycles total.
REQ-034 Instr=0111_100_000 (NOT R4) -> T2 Gin, ALUcont=0101, Rout=0, Gout=0, ExtOut=0; T3 Rin[4]; Run held high throughout has no effect in T1-T3.
REQ-035 Clear asserted asynchronously during T2 of a SUB -> Tstep=00 and all outputs 0 before the next edge; no Rin pulse follows.
REQ-036 Instr=1010_000_000 -> with ILLEGAL_TRAP_EN: Illegal=1, Tstep stays 01 for 5 cycles, Done never asserts until Clear; without: Done=1 in T1, Illegal=0, back to T0.
REQ-037 Instr=0001_011_111 (LDI R3,7) -> T1 ExtOut=1, Rin=0000_1000, Done=1; Run=0 afterwards keeps Tstep=00 and IR_EN=0.

Source files
------------

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer -- timestep control unit for a simple bus-based processor.
//
// A two-bit timestep FSM (T0..T3) walks each instruction through its bus
// transfers. All control outputs are combinational from the current timestep
// and the instruction word. The instruction register captures on the falling
// edge, so Instr is already stable when T1 begins.
//
// Optional feature: define ILLEGAL_TRAP_EN to trap illegal opcodes (1xxx).
// The trap raises a sticky Illegal flag and parks the FSM in T1 until Clear.
// When the macro is undefined, illegal opcodes run as a one-step NOP.
//
// Ports
//   CLKb     in   1  clock; state updates on the rising edge
//   Clear    in   1  asynchronous active-high reset; forces all outputs to 0
//   Run      in   1  start request, sampled only in T0
//   Instr    in  10  [9:6] opcode, [5:3] Rx, [2:0] Ry
//   IR_EN    out  1  instruction register load enable (equals Run in T0)
//   Rin      out  8  one-hot register write enables
//   Rout     out  8  one-hot register bus-drive enables
//   Ain      out  1  A register load
//   Gin      out  1  G register load
//   Gout     out  1  G register bus drive
//   ExtOut   out  1  immediate (zero-extended Ry) bus drive
//   ALUcont  out  4  ALU operation select; 0 whenever Gin is 0
//   Done     out  1  final step of the current instruction
//   Tstep    out  2  current timestep
//   Illegal  out  1  illegal-opcode trap flag (tied 0 without the trap)
// ---------------------------------------------------------------------------
module instr_sequencer (
  input  logic       CLKb,
  input  logic       Clear,
  input  logic       Run,
  input  logic [9:0] Instr,
  output logic       IR_EN,
  output logic [7:0] Rin,
  output logic [7:0] Rout,
  output logic       Ain,
  output logic       Gin,
  output logic       Gout,
  output logic       ExtOut,
  output logic [3:0] ALUcont,
  output logic       Done,
  output logic [1:0] Tstep,
  output logic       Illegal
);

  localparam logic [1:0] T0 = 2'b00;
  localparam logic [1:0] T1 = 2'b01;
  localparam logic [1:0] T2 = 2'b10;
  localparam logic [1:0] T3 = 2'b11;

  localparam logic [3:0] OP_MOV = 4'b0000;
  localparam logic [3:0] OP_LDI = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_NOT = 4'b0101;

  logic [1:0] state;
  logic [1:0] state_next;
  logic [3:0] opcode;
  logic [7:0] rx_hot;
  logic [7:0] ry_hot;
  logic       op_illegal;
  logic       trap_hold;
  logic [3:0] alu_sel;

  assign opcode     = Instr[9:6];
  assign rx_hot     = 8'd1 << Instr[5:3];
  assign ry_hot     = 8'd1 << Instr[2:0];
  assign op_illegal = opcode[3];
  assign Tstep      = state;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge CLKb or posedge Clear) begin
    if (Clear) begin
      illegal_q <= 1'b0;
    end else if (state == T1 && op_illegal) begin
      illegal_q <= 1'b1;
    end
  end

  // The flag shows in the very first T1 cycle, not one edge later.
  assign trap_hold = op_illegal;
  assign Illegal   = !Clear && (illegal_q || (state == T1 && op_illegal));
`else
  assign trap_hold = 1'b0;
  assign Illegal   = 1'b0;
`endif

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of block ordering.
  always_ff @(posedge CLKb or posedge Clear) begin
    if (Clear) begin
      state <= T0;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    alu_sel = ALU_ADD;
    case (opcode)
      OP_ADD:  alu_sel = ALU_ADD;
      OP_SUB:  alu_sel = ALU_SUB;
      OP_AND:  alu_sel = ALU_AND;
      OP_OR:   alu_sel = ALU_OR;
      OP_XOR:  alu_sel = ALU_XOR;
      OP_NOT:  alu_sel = ALU_NOT;
      default: alu_sel = ALU_ADD;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave a signal unassigned and infer a latch.
    state_next = state;
    IR_EN      = 1'b0;
    Rin        = 8'd0;
    Rout       = 8'd0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    Gout       = 1'b0;
    ExtOut     = 1'b0;
    ALUcont    = ALU_ADD;
    Done       = 1'b0;

    case (state)
      T0: begin
        IR_EN = Run;
        if (Run) state_next = T1;
      end
      T1: begin
        if (op_illegal) begin
          if (trap_hold) begin
            state_next = T1;
          end else begin
            Done       = 1'b1;
            state_next = T0;
          end
        end else begin
          case (opcode)
            OP_MOV: begin
              Rout       = ry_hot;
              Rin        = rx_hot;
              Done       = 1'b1;
              state_next = T0;
            end
            OP_LDI: begin
              ExtOut     = 1'b1;
              Rin        = rx_hot;
              Done       = 1'b1;
              state_next = T0;
            end
            default: begin
              Rout       = rx_hot;
              Ain        = 1'b1;
              state_next = T2;
            end
          endcase
        end
      end
      T2: begin
        // NOT is unary: G is loaded from A alone, nothing drives the bus.
        if (opcode != OP_NOT) Rout = ry_hot;
        Gin        = 1'b1;
        ALUcont    = alu_sel;
        state_next = T3;
      end
      default: begin
        Gout       = 1'b1;
        Rin        = rx_hot;
        Done       = 1'b1;
        state_next = T0;
      end
    endcase

    // Async Clear already forces T0; this also blanks IR_EN while Clear is high.
    if (Clear) begin
      IR_EN   = 1'b0;
      Rin     = 8'd0;
      Rout    = 8'd0;
      Ain     = 1'b0;
      Gin     = 1'b0;
      Gout    = 1'b0;
      ExtOut  = 1'b0;
      ALUcont = ALU_ADD;
      Done    = 1'b0;
    end
  end

endmodule
